pll_reset_sequencer: RTL

- Sequences startup and recovery of the CC_PLL clock-generation block and the resets downstream of it.
- Pulses the PLL reset, waits for a lock that stays stable, then releases the core reset and the peripheral reset (e.g. the ST7789 driver) in order.
- Retries the PLL on lock timeout. On lock loss it re-asserts all resets and restarts.
- Runs on the board reference clock, so it keeps operating while the PLL output is absent.

---
 rtl/pll_reset_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Startup/recovery sequencer for the PLL and the core/peripheral resets behind it.
// Runs on the board reference clock so it keeps working while the PLL output is absent.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned RST_STAGE_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clock_in,
    input  logic       rst_in,
    input  logic       pll_lock_in,
    output logic       pll_rst_out,
    output logic       rst_core_out,
    output logic       rst_periph_out,
    output logic       ready_out,
    output logic       fault_out,
    output logic       lock_lost_out,
    output logic [1:0] retry_count_out
);

    localparam int unsigned MAX_AB = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > RST_STAGE_CYCLES) ? MAX_AB : RST_STAGE_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(RST_STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N   = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_N      = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRIES);

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] REL_CORE  = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] FAULT     = 3'd5;

    logic             lock_meta, lock_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] stage_q, stage_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [1:0]       retry_q, retry_d;
    logic             lost_d;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        tmo_d   = tmo_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (stage_q == STAGE_LAST) begin
                    state_d = WAIT_LOCK;
                    stage_d = '0;
                    tmo_d   = '0;
                    stab_d  = '0;
                end else begin
                    stage_d = stage_q + CNT_W'(1);
                end
            end
            WAIT_LOCK, STABLE: begin
                tmo_d   = tmo_q + CNT_W'(1);
                stab_d  = lock_s ? stab_q + CNT_W'(1) : '0;
                state_d = lock_s ? STABLE : WAIT_LOCK;
                // Acceptance takes priority over a timeout landing on the same edge.
                if (lock_s && (stab_d >= STABLE_N)) begin
                    state_d = REL_CORE;
                    retry_d = '0;
                    tmo_d   = '0;
                    stab_d  = '0;
                    stage_d = '0;
                end else if (tmo_d >= TMO_N) begin
                    retry_d = retry_q + 2'd1;
                    state_d = (retry_d == RETRY_MAX) ? FAULT : PLL_RST;
                    tmo_d   = '0;
                    stab_d  = '0;
                    stage_d = '0;
                end
            end
            REL_CORE: begin
                if (!lock_s) begin
                    lost_d = 1'b1;
                end else if (stage_q == STAGE_LAST) begin
                    state_d = RUN;
                    stage_d = '0;
                end else begin
                    stage_d = stage_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) lost_d = 1'b1;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
                stage_d = '0;
                tmo_d   = '0;
                stab_d  = '0;
            end
        endcase
        if (lost_d) begin
            state_d = PLL_RST;
            stage_d = '0;
            tmo_d   = '0;
            stab_d  = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            state_q         <= PLL_RST;
            stage_q         <= '0;
            tmo_q           <= '0;
            stab_q          <= '0;
            retry_q         <= '0;
            pll_rst_out     <= 1'b1;
            rst_core_out    <= 1'b1;
            rst_periph_out  <= 1'b1;
            ready_out       <= 1'b0;
            fault_out       <= 1'b0;
            lock_lost_out   <= 1'b0;
            retry_count_out <= '0;
        end else begin
            lock_meta       <= pll_lock_in;
            lock_s          <= lock_meta;
            state_q         <= state_d;
            stage_q         <= stage_d;
            tmo_q           <= tmo_d;
            stab_q          <= stab_d;
            retry_q         <= retry_d;
            // Outputs are decoded from the next state so they change on the transition edge.
            pll_rst_out     <= (state_d == PLL_RST) || (state_d == FAULT);
            rst_core_out    <= !((state_d == REL_CORE) || (state_d == RUN));
            rst_periph_out  <= (state_d != RUN);
            ready_out       <= (state_d == RUN);
            fault_out       <= (state_d == FAULT);
            lock_lost_out   <= lost_d;
            retry_count_out <= retry_d;
        end
    end

endmodule
